// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
// The build macro DMEM_ARB_RR_EN is consumed by dmem_arb_pick and dmem_arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } dmem_arb_state_t;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_DBG = 1;
  localparam int unsigned N_REQ    = 2;

  localparam logic PORT_CPU_IDX = 1'(PORT_CPU);
  localparam logic PORT_DBG_IDX = 1'(PORT_DBG);

  // One-hot acknowledge vector for a single winning port index.
  function automatic logic [N_REQ-1:0] port_onehot(input logic idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner select for the two memory requesters.
// DMEM_ARB_RR_EN selects round-robin tie-breaking; otherwise port 0 always wins a tie.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last_grant,
  output logic             grant_idx,
  output logic             grant_vld
);

`ifndef DMEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Winner select: a lone request always wins; a tie follows the configured policy.
  always_comb begin
    grant_vld = |req;
    grant_idx = PORT_CPU_IDX;
    case (req)
      2'b01: grant_idx = PORT_CPU_IDX;
      2'b10: grant_idx = PORT_DBG_IDX;
      2'b11: begin
`ifdef DMEM_ARB_RR_EN
        grant_idx = ~last_grant;
`else
        grant_idx = PORT_CPU_IDX;
`endif
      end
      default: grant_idx = PORT_CPU_IDX;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises CPU (port 0) and debug/loader (port 1) accesses onto the single-port data memory.
// Build macro DMEM_ARB_RR_EN enables round-robin tie-breaking; default build is fixed port-0 priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [N_REQ-1:0]  ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  dmem_arb_state_t   state_r;
  logic              win_r;
  logic              we_r;
  logic              mem_write_r;
  logic              last_grant_s;
  logic              grant_idx_s;
  logic              grant_vld_s;
  logic              win_we_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;

`ifdef DMEM_ARB_RR_EN
  logic last_grant_r;
  assign last_grant_s = last_grant_r;
`else
  assign last_grant_s = PORT_DBG_IDX;
`endif

  dmem_arb_pick u_pick (
    .req        (req),
    .last_grant (last_grant_s),
    .grant_idx  (grant_idx_s),
    .grant_vld  (grant_vld_s)
  );

  // Transaction fields of the port selected this cycle.
  always_comb begin
    if (grant_idx_s) begin
      win_we_s    = we[1];
      win_addr_s  = addr1;
      win_wdata_s = wdata1;
    end else begin
      win_we_s    = we[0];
      win_addr_s  = addr0;
      win_wdata_s = wdata0;
    end
  end

  // Masking with rst keeps a write that is in ACCESS from landing on the reset edge itself.
  assign mem_write = mem_write_r & ~rst;

  // Sequencer: IDLE grants and latches, ACCESS drives the memory, ACK pulses the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      win_r        <= PORT_CPU_IDX;
      we_r         <= 1'b0;
      ack          <= '0;
      rdata        <= '0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      mem_write_r  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_grant_r <= PORT_DBG_IDX;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          ack <= '0;
          if (grant_vld_s) begin
            state_r      <= ACCESS;
            win_r        <= grant_idx_s;
            we_r         <= win_we_s;
            mem_address  <= win_addr_s;
            mem_wdata    <= win_wdata_s;
            mem_write_r  <= win_we_s;
`ifdef DMEM_ARB_RR_EN
            last_grant_r <= grant_idx_s;
`endif
          end else begin
            state_r     <= IDLE;
            mem_write_r <= 1'b0;
          end
        end
        ACCESS: begin
          mem_write_r <= 1'b0;
          if (!we_r) begin
            rdata <= mem_rdata;
          end else begin
            rdata <= rdata;
          end
          ack     <= port_onehot(win_r);
          state_r <= ACK;
        end
        ACK: begin
          ack         <= '0;
          mem_write_r <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          ack         <= '0;
          mem_write_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a 256-word memory model.
// Tie-order expectations follow DMEM_ARB_RR_EN when the bench is built with it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  ack;
  logic [31:0] rdata, mem_address, mem_wdata, mem_rdata;
  logic        mem_write;
  logic        mem_init;
  logic [31:0] mem [0:255];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .we          (we),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack         (ack),
    .rdata       (rdata),
    .mem_address (mem_address),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  assign mem_rdata = mem[mem_address[7:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
    end else if (mem_write) begin
      mem[mem_address[7:0]] <= mem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1;
    req = 2'b11; we = 2'b11;
    addr0 = 32'h30; addr1 = 32'h31; wdata0 = 32'hFFFF_FFFF; wdata1 = 32'hAAAA_AAAA;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (ack !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", ack); end
      checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
      checks++; if (mem_address !== 32'h0) begin failures++; $display("FAIL reset_mem_address got=%h exp=0", mem_address); end
    end
    rst = 1'b0; mem_init = 1'b0; req = 2'b00; we = 2'b00;
    step();
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL reset_idle_ack got=%b exp=00", ack); end
    checks++; if (mem[8'h30] !== 32'h30) begin failures++; $display("FAIL reset_mem30 got=%h exp=30", mem[8'h30]); end
    checks++; if (mem[8'h31] !== 32'h31) begin failures++; $display("FAIL reset_mem31 got=%h exp=31", mem[8'h31]); end
  endtask

  task automatic test_port0_write_read();
    req = 2'b01; we = 2'b01; addr0 = 32'h05; wdata0 = 32'hDEAD_BEEF;
    step();
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL p0w_mem_write got=%b exp=1", mem_write); end
    checks++; if (mem_address !== 32'h05) begin failures++; $display("FAIL p0w_addr got=%h exp=05", mem_address); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL p0w_wdata got=%h exp=deadbeef", mem_wdata); end
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL p0w_early_ack got=%b exp=00", ack); end
    step();
    checks++; if (ack !== 2'b01) begin failures++; $display("FAIL p0w_ack got=%b exp=01", ack); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL p0w_write_one_cycle got=%b exp=0", mem_write); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL p0w_rdata_kept got=%h exp=0", rdata); end
    checks++; if (mem[8'h05] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL p0w_mem got=%h exp=deadbeef", mem[8'h05]); end
    req = 2'b00;
    step();
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL p0w_ack_pulse got=%b exp=00", ack); end
    req = 2'b01; we = 2'b00; addr0 = 32'h05;
    step();
    step();
    checks++; if (ack !== 2'b01) begin failures++; $display("FAIL p0r_ack got=%b exp=01", ack); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL p0r_rdata got=%h exp=deadbeef", rdata); end
    req = 2'b00;
    step();
  endtask

  task automatic test_port1_read();
    int wr_seen;
    wr_seen = 0;
    req = 2'b10; we = 2'b00; addr1 = 32'h10;
    step();
    if (mem_write !== 1'b0) wr_seen++;
    checks++; if (mem_address !== 32'h10) begin failures++; $display("FAIL p1r_addr got=%h exp=10", mem_address); end
    step();
    if (mem_write !== 1'b0) wr_seen++;
    checks++; if (ack !== 2'b10) begin failures++; $display("FAIL p1r_ack got=%b exp=10", ack); end
    checks++; if (rdata !== 32'h10) begin failures++; $display("FAIL p1r_rdata got=%h exp=10", rdata); end
    req = 2'b00;
    step();
    checks++; if (wr_seen !== 0) begin failures++; $display("FAIL p1r_no_write got=%0d exp=0", wr_seen); end
  endtask

  task automatic test_tie();
    logic [1:0]  exp_ack [4];
    logic [31:0] exp_rd  [4];
`ifdef DMEM_ARB_RR_EN
    exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rd  = '{32'h01, 32'h02, 32'h01, 32'h02};
`else
    exp_ack = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_rd  = '{32'h01, 32'h01, 32'h01, 32'h01};
`endif
    req = 2'b11; we = 2'b00; addr0 = 32'h01; addr1 = 32'h02;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin
        step();
        checks++; if (ack !== 2'b00) begin failures++; $display("FAIL tie_gap_ack%0d got=%b exp=00", k, ack); end
        step();
      end
      step();
      checks++; if (ack !== exp_ack[k]) begin failures++; $display("FAIL tie_ack%0d got=%b exp=%b", k, ack, exp_ack[k]); end
      checks++; if (rdata !== exp_rd[k]) begin failures++; $display("FAIL tie_rdata%0d got=%h exp=%h", k, rdata, exp_rd[k]); end
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_reset_mid_access();
    req = 2'b01; we = 2'b01; addr0 = 32'h20; wdata0 = 32'h1234_5678;
    step();
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL rma_access got=%b exp=1", mem_write); end
    rst = 1'b1; req = 2'b00;
    #1;
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rma_write_masked got=%b exp=0", mem_write); end
    step();
    rst = 1'b0;
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL rma_no_ack got=%b exp=00", ack); end
    checks++; if (mem[8'h20] !== 32'h20) begin failures++; $display("FAIL rma_mem got=%h exp=20", mem[8'h20]); end
    step();
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL rma_no_late_ack got=%b exp=00", ack); end
    req = 2'b10; we = 2'b00; addr1 = 32'h20;
    step();
    step();
    checks++; if (ack !== 2'b10) begin failures++; $display("FAIL rma_idle_ack got=%b exp=10", ack); end
    checks++; if (rdata !== 32'h20) begin failures++; $display("FAIL rma_readback got=%h exp=20", rdata); end
    req = 2'b00;
    step();
  endtask

  task automatic test_alias_drop();
    req = 2'b01; we = 2'b00; addr0 = 32'h105;
    step();
    checks++; if (mem_address !== 32'h105) begin failures++; $display("FAIL alias_addr got=%h exp=105", mem_address); end
    req = 2'b00; addr0 = 32'h77;
    step();
    checks++; if (ack !== 2'b01) begin failures++; $display("FAIL alias_ack got=%b exp=01", ack); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL alias_rdata got=%h exp=deadbeef", rdata); end
    step();
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL alias_ack_once got=%b exp=00", ack); end
    step();
    step();
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL alias_no_regrant got=%b exp=00", ack); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL alias_mem_write got=%b exp=0", mem_write); end
  endtask

  initial begin
    test_reset();
    test_port0_write_read();
    test_port1_read();
    test_tie();
    test_reset_mid_access();
    test_alias_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
